// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: byte FIFO between the UART receiver and transmitter in the
// loopback path. Received bytes are buffered, then handed to the transmitter
// one at a time, waiting for each frame's done pulse before the next strobe.
// Optional feature: define UART_FIFO_CRLF_EN to follow every transmitted
// 0x0D with an inserted 0x0A (no extra FIFO entry consumed).
module uart_byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_rx_dv,
    input  logic [7:0]    i_rx_data,
    output logic          o_tx_dv,
    output logic [7:0]    o_tx_data,
    input  logic          i_tx_active,
    input  logic          i_tx_done,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_overflow,
    input  logic          i_ovf_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);

    logic [7:0]    mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          tx_dv_q, tx_dv_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          ovf_q, ovf_d;

    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic          drop;

    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);

    // Next-state logic: push/pop/drop decode, drain state machine, counters.
    always_comb begin
        // A pop is only possible from IDLE towards a transmitter that is free;
        // this also keeps a freshly reset block from strobing a busy transmitter.
        pop  = (state_q == IDLE) && !empty && !i_tx_active;
        // A full FIFO still accepts a byte when a slot frees on the same edge.
        push = i_rx_dv && (!full || pop);
        drop = i_rx_dv && full && !pop;

        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        tx_dv_d   = 1'b0;
        tx_data_d = tx_data_q;
        ovf_d     = (ovf_q && !i_ovf_clr) || drop;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d = mem[rd_ptr_q];
                    rd_ptr_d  = rd_ptr_q + PTR_ONE;
                    tx_dv_d   = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (i_tx_done) begin
`ifdef UART_FIFO_CRLF_EN
                    // A finished CR is chased by an LF; the LF itself ends normally.
                    if (tx_data_q == 8'h0D) begin
                        tx_data_d = 8'h0A;
                        tx_dv_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control and output registers, cleared by the asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_dv_q   <= 1'b0;
            tx_data_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_dv_q   <= tx_dv_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    // Byte storage; contents need no reset because the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_rx_data;
        end
    end

    assign o_tx_dv    = tx_dv_q;
    assign o_tx_data  = tx_data_q;
    assign o_count    = count_q;
    assign o_empty    = empty;
    assign o_full     = full;
    assign o_overflow = ovf_q;

endmodule
